// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the programmable sequence generator.
package seq_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_REPEAT  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Zero length becomes 1; anything above max_len saturates.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_tick_div.sv
// Enabled tick divider: one tick every div_max_i+1 enabled cycles, count cleared by clr_i.
module seq_tick_div #(
    parameter int unsigned DIV_W = 26
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_max_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == div_max_i);

    // A count above a freshly lowered div_max wraps through the full width.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/seq_gen_prog.sv
// Programmable serial bit-sequence generator with divided step rate.
// Define SEQ_GEN_MATCH_EN to add the din/match serial sequence detector.
module seq_gen_prog
    import seq_gen_pkg::*;
#(
    parameter int unsigned        MAX_LEN = 16,
    parameter int unsigned        LEN_W   = 5,
    parameter int unsigned        DIV_W   = 26,
    parameter logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(16'b0000_0000_0001_0110),
    parameter logic [LEN_W-1:0]   LEN_RST = LEN_W'(5)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DIV_W-1:0]   div_max,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic               mode,
    input  logic               start,
    input  logic               stop,
    output logic               bit_out,
    output logic [LEN_W-1:0]   idx,
    output logic               tick,
    output logic               busy,
    output logic               done,
    output logic               led
`ifdef SEQ_GEN_MATCH_EN
   ,input  logic               din,
    output logic               match
`endif
);

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               mode_q, mode_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic               bit_q, bit_d;
    logic               led_q, led_d;

    logic               tick_w, run_en, start_now, load_now;
    logic [LEN_W-1:0]   len_clamped, len_eff, idx_next;
    logic [MAX_LEN-1:0] pat_eff;

    function automatic logic pick(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
        pick = 1'b0;
        for (int unsigned k = 0; k < MAX_LEN; k++)
            if (k == 32'(i))
                pick = p[k];
    endfunction

    assign start_now   = (state_q == IDLE) && start;
    assign load_now    = (state_q == IDLE) && load;
    assign run_en      = (state_q == RUN) && en;
    assign len_clamped = LEN_W'(clamp_len(32'(len), MAX_LEN));
    // A load on the start edge must feed the start itself.
    assign pat_eff     = load_now ? pattern : pattern_q;
    assign len_eff     = load_now ? len_clamped : len_q;

    seq_tick_div #(.DIV_W(DIV_W)) u_div (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (run_en),
        .clr_i     (start_now),
        .div_max_i (div_max),
        .tick_o    (tick_w)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                if (stop)
                    state_d = IDLE;
                else if (tick_w && idx_q == '0 && mode_q == MODE_ONESHOT)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        idx_next  = '0;
        led_d     = led_q ^ tick_w;
        if (load_now) begin
            pattern_d = pattern;
            len_d     = len_clamped;
        end
        unique case (state_q)
            IDLE: begin
                bit_d = 1'b0;
                if (start) begin
                    idx_next = len_eff - LEN_W'(1);
                    idx_d    = idx_next;
                    bit_d    = pick(pat_eff, idx_next);
                    mode_d   = mode;
                end
            end
            RUN: begin
                if (stop) begin
                    bit_d = 1'b0;
                end else if (tick_w) begin
                    if (idx_q == '0 && mode_q == MODE_ONESHOT) begin
                        bit_d = 1'b0;
                    end else begin
                        idx_next = (idx_q == '0) ? len_q - LEN_W'(1) : idx_q - LEN_W'(1);
                        idx_d    = idx_next;
                        bit_d    = pick(pattern_q, idx_next);
                    end
                end
            end
            default: bit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= PAT_RST;
            len_q     <= LEN_RST;
            mode_q    <= MODE_REPEAT;
            idx_q     <= '0;
            bit_q     <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            bit_q     <= bit_d;
            led_q     <= led_d;
        end
    end

    always_comb begin
        busy    = (state_q == RUN);
        done    = (state_q == DONE);
        bit_out = bit_q;
        idx     = idx_q;
        tick    = tick_w;
        led     = led_q;
    end

`ifdef SEQ_GEN_MATCH_EN
    logic [MAX_LEN-1:0] sr_q, len_mask;
    logic               shifted_q;

    always_comb begin
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++)
            if (i < 32'(len_q))
                len_mask[i] = 1'b1;
    end

    // Compare one cycle after each shift so the pulse follows its tick.
    assign match = shifted_q && (((sr_q ^ pattern_q) & len_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst || start_now) begin
            sr_q      <= '0;
            shifted_q <= 1'b0;
        end else begin
            shifted_q <= tick_w;
            if (tick_w)
                sr_q <= {sr_q[MAX_LEN-2:0], din};
        end
    end
`endif

endmodule

// File: doc/seq_gen_prog.md
Name: seq_gen_prog

Overview:
Programmable serial bit-sequence generator. It is the parametrised successor to the fixed 10110 generator with its free-running divider. The pattern and length are loaded at runtime. Output steps at a programmable divided rate, in repeat or one-shot mode, with start/stop control and status flags. It drives board LEDs or serial test stimulus from the fast board clock.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..64)
LEN_W, 5, width of length field; must hold MAX_LEN
DIV_W, 26, width of divider terminal-count field
PAT_RST, 16'b0000_0000_0001_0110, pattern register reset value (MAX_LEN bits)
LEN_RST, 5, length register reset value

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  divider enable; low freezes divider and sequence position
div_max  in  DIV_W  divider terminal count; one step every div_max+1 enabled cycles
load  in  1  capture pattern/len (honoured in IDLE only)
pattern  in  MAX_LEN  bit pattern, bit len-1 emitted first
len  in  LEN_W  pattern length
mode  in  1  0 = repeat, 1 = one-shot (sampled at start)
start  in  1  begin sequence (IDLE only)
stop  in  1  abort sequence
bit_out  out  1  current sequence bit (registered)
idx  out  LEN_W  current bit index
tick  out  1  one-cycle step strobe
busy  out  1  high in RUN
done  out  1  one-cycle pulse at one-shot completion
led  out  1  toggles on every tick (heartbeat)

Behaviour:
- Clock `clk`; reset `rst` is synchronous and active-high. Everything is in one clock domain.
- Reset values:
  - state=IDLE; bit_out=0, idx=0, tick=0, busy=0, done=0, led=0.
  - Divider count=0.
  - pattern_reg=PAT_RST, len_reg=LEN_RST, mode_reg=0.
- Reset asserted mid-RUN returns all of the above on the next edge.
- Length clamp at load: len=0 is stored as 1; len>MAX_LEN is stored as MAX_LEN.
- Divider:
  - Counts only in RUN with en=1.
  - When cnt==div_max: tick=1 for one cycle, cnt<=0. Otherwise cnt<=cnt+1.
  - div_max=0 gives a tick every enabled cycle.
  - Count is cleared on entry to RUN.
  - div_max changes take effect immediately; if cnt>div_max, the count wraps through its full width. This is legal and must not hang.
- States:
  - IDLE:
    - load=1 captures pattern/len.
    - start=1 -> RUN, with idx<=len_reg-1 and bit_out<=pattern_reg[len_reg-1] on the same edge, mode_reg<=mode.
    - load and start on the same edge: the new pattern/len are used for the start.
    - bit_out=0.
  - RUN:
    - busy=1. On tick:
      - if idx==0 and mode_reg=0: idx<=len_reg-1.
      - if idx==0 and mode_reg=1: -> DONE.
      - otherwise idx<=idx-1.
    - bit_out<=pattern_reg[new idx] on the same edge, so each bit is held exactly div_max+1 enabled cycles.
    - load and start are ignored.
    - stop=1 -> IDLE next edge, bit_out<=0, no done.
    - stop has priority over tick.
  - DONE:
    - done=1 and bit_out=0 for one cycle, then -> IDLE.
    - start is ignored in this cycle.
- led toggles on each tick.

Optional Feature:
Macro SEQ_GEN_MATCH_EN adds a serial sequence detector and its ports.
- Added ports: din (in 1) and match (out 1).
- On every tick, din is shifted into a MAX_LEN shift register.
- match pulses high for one cycle when the low len_reg bits equal pattern_reg[len_reg-1:0]. Overlapping matches are allowed.
- The shift register clears on rst and on entry to RUN.
- Without the macro, neither port nor any detector logic exists.

Decomposition:
- Package seq_gen_pkg holds:
  - the state encoding constants IDLE/RUN/DONE;
  - mode constants MODE_REPEAT=0 and MODE_ONESHOT=1;
  - a function clamp_len.
- One sub-module, seq_tick_div: parametrised DIV_W tick divider with en, clr, div_max inputs and a tick output.
- The FSM, pattern register and detector stay in seq_gen_prog.

Test Plan:
1. Reset, then load pattern=10110, len=5, mode=0, div_max=0, start -> bit_out is 1,0,1,1,0,1,0,1,1,0… one bit per cycle; idx 4,3,2,1,0,4…
2. Same pattern, mode=1, div_max=2 -> each bit held 3 cycles. After the 15th cycle the state goes to DONE: done=1 for 1 cycle, busy falls, bit_out=0; led has toggled 5 times.
3. Mid-RUN stop at idx=2 -> IDLE next edge, bit_out=0, no done. A later start restarts at idx=4.
4. Load len=0 and len=20 (MAX_LEN=16) -> stored len 1 and 16. A one-shot of len 1 gives a single bit, then done.
5. en held low for 10 cycles mid-RUN -> bit_out, idx and divider frozen, then resume exactly where they stopped. Asserting rst while busy -> all outputs at reset values next edge.
6. (SEQ_GEN_MATCH_EN) Pattern 10110, din=1011010110 on ticks -> match pulses after the 5th and 10th ticks. Also drive an overlapping stream 1011011 on ticks -> match pulses after the 5th tick only.
